// File: rtl/icnd2110_rx_if.sv
// icnd2110_rx_if
//   Bundles the serial input pair and the decoded-output bus of the
//   ICND2110 stream receiver.
//   Signals:
//     sclk_in, sdata_in  serial clock/data from the LED chain (async)
//     wr_data/wr_addr/wr_strobe       decoded PWM word write port
//     reg_word/reg_valid              config register word and update pulse
//     frame_done/frame_words          end-of-frame pulse and committed count
//     frame_error                     framing-violation pulse
//     busy                            frame in progress
//   Modports: slave = receiver side, master = stream source / consumer side.
interface icnd2110_rx_if #(
    parameter int ADDRESS_BUS_WIDTH = 12
) ();
    logic                       sclk_in;
    logic                       sdata_in;
    logic [15:0]                wr_data;
    logic [ADDRESS_BUS_WIDTH:0] wr_addr;
    logic                       wr_strobe;
    logic [15:0]                reg_word;
    logic                       reg_valid;
    logic                       frame_done;
    logic [ADDRESS_BUS_WIDTH:0] frame_words;
    logic                       frame_error;
    logic                       busy;

    modport slave (
        input  sclk_in, sdata_in,
        output wr_data, wr_addr, wr_strobe, reg_word, reg_valid,
               frame_done, frame_words, frame_error, busy
    );

    modport master (
        output sclk_in, sdata_in,
        input  wr_data, wr_addr, wr_strobe, reg_word, reg_valid,
               frame_done, frame_words, frame_error, busy
    );
endinterface

// File: rtl/icnd2110_rx.sv
// icnd2110_rx
//   Serial receiver/decoder for the ICND2110 LED-driver stream. Finds the
//   start marker, captures the config register word and the per-chip PWM
//   words, and writes the PWM words into a word-addressed memory port using
//   the same address layout as the icnd2110 transmitter.
//   Ports:
//     clk   system clock, at least 4x the sclk_in rate
//     rst   synchronous, active-high reset
//     bus   icnd2110_rx_if.slave: sclk_in/sdata_in in; write port,
//           reg_word/reg_valid, frame_done/frame_words, frame_error, busy out
//   Optional feature: define ICND2110_RX_TIMEOUT_EN to abort a busy frame
//   after TIMEOUT_CYCLES clk cycles without an sclk rising edge.
module icnd2110_rx #(
    parameter int WORD_COUNT        = 336,
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int START_MIN         = 124,
    parameter int START_MAX         = 132
`ifdef ICND2110_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES    = 4096
`endif
) (
    input logic          clk,
    input logic          rst,
    icnd2110_rx_if.slave bus
);
    localparam int          AW         = ADDRESS_BUS_WIDTH + 1;
    localparam logic [15:0] WORD_LIMIT = 16'(WORD_COUNT);
    localparam logic [7:0]  RUN_MIN    = 8'(START_MIN);
    localparam logic [7:0]  RUN_MAX    = 8'(START_MAX);

    typedef enum logic [2:0] {
        WAIT_ZERO,
        HUNT,
        LEAD_BLANK,
        REG,
        BLANK,
        HALF_A,
        HALF_B
    } state_t;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic sdata_meta, sdata_sync;
    logic bit_evt, bit_val;

    state_t         state;
    logic [7:0]     run;
    logic [6:0]     cnt;
    logic [14:0]    reg_sh;
    logic [95:0]    shreg;
    logic           next_b;
    logic [7:0]     chip;

    logic [95:0]    cbuf;
    logic           commit_active;
    logic [2:0]     commit_k;
    logic           commit_half_b;
    logic [15:0]    commit_base;
    logic [AW-1:0]  commit_count;
    logic [3:0]     commit_off;
    logic [15:0]    commit_addr;

    logic [15:0]    wr_data_q;
    logic [AW-1:0]  wr_addr_q;
    logic           wr_strobe_q;
    logic [15:0]    reg_word_q;
    logic           reg_valid_q;
    logic           frame_done_q;
    logic [AW-1:0]  frame_words_q;
    logic           frame_error_q;
    logic           busy_q;

`ifdef ICND2110_RX_TIMEOUT_EN
    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    logic [IDLE_W-1:0] idle_cnt;
`endif

    // sclk and sdata share an identical synchronizer depth, so the data bit
    // captured alongside the edge detect is the value present at the sclk rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta  <= 1'b0;
            sclk_sync  <= 1'b0;
            sclk_prev  <= 1'b0;
            sdata_meta <= 1'b0;
            sdata_sync <= 1'b0;
            bit_evt    <= 1'b0;
            bit_val    <= 1'b0;
        end else begin
            sclk_meta  <= bus.sclk_in;
            sclk_sync  <= sclk_meta;
            sclk_prev  <= sclk_sync;
            sdata_meta <= bus.sdata_in;
            sdata_sync <= sdata_meta;
            bit_evt    <= sclk_sync & ~sclk_prev;
            bit_val    <= sdata_sync;
        end
    end

    // HALF_A words land at chip*12 + 5..0, HALF_B words at chip*12 + 11..6.
    always_comb begin
        commit_off  = commit_half_b ? (4'd11 - {1'b0, commit_k})
                                    : (4'd5  - {1'b0, commit_k});
        commit_addr = commit_base + {12'd0, commit_off};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_ZERO;
            run           <= '0;
            cnt           <= '0;
            reg_sh        <= '0;
            shreg         <= '0;
            next_b        <= 1'b0;
            chip          <= '0;
            cbuf          <= '0;
            commit_active <= 1'b0;
            commit_k      <= '0;
            commit_half_b <= 1'b0;
            commit_base   <= '0;
            commit_count  <= '0;
            wr_data_q     <= '0;
            wr_addr_q     <= '0;
            wr_strobe_q   <= 1'b0;
            reg_word_q    <= '0;
            reg_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_words_q <= '0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ICND2110_RX_TIMEOUT_EN
            idle_cnt      <= '0;
`endif
        end else begin
            wr_strobe_q   <= 1'b0;
            reg_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;

            // Commit engine: drains the captured half, word 0 first, one word
            // per clk. The buffer is shifted so the current word is always on top.
            if (commit_active) begin
                wr_data_q <= cbuf[95:80];
                wr_addr_q <= commit_addr[AW-1:0];
                if (commit_addr < WORD_LIMIT) begin
                    wr_strobe_q  <= 1'b1;
                    commit_count <= commit_count + 1'b1;
                end
                cbuf     <= {cbuf[79:0], 16'd0};
                commit_k <= commit_k + 3'd1;
                if (commit_k == 3'd5) begin
                    commit_active <= 1'b0;
                end
            end

            if (bit_evt) begin
                case (state)
                    WAIT_ZERO: begin
                        if (!bit_val) begin
                            state <= HUNT;
                            run   <= '0;
                        end
                    end

                    // Only a ones-run inside the start window is a frame start;
                    // the longer end marker falls outside it and is ignored.
                    HUNT: begin
                        if (bit_val) begin
                            if (run != 8'hFF) begin
                                run <= run + 8'd1;
                            end
                        end else if (run >= RUN_MIN && run <= RUN_MAX) begin
                            busy_q       <= 1'b1;
                            state        <= LEAD_BLANK;
                            cnt          <= 7'd1;
                            commit_count <= '0;
                        end else begin
                            run <= '0;
                        end
                    end

                    LEAD_BLANK: begin
                        if (bit_val) begin
                            frame_error_q <= 1'b1;
                            busy_q        <= 1'b0;
                            commit_active <= 1'b0;
                            state         <= WAIT_ZERO;
                        end else if (cnt == 7'd15) begin
                            state <= REG;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end

                    REG: begin
                        reg_sh <= {reg_sh[13:0], bit_val};
                        if (cnt == 7'd15) begin
                            reg_word_q  <= {reg_sh, bit_val};
                            reg_valid_q <= 1'b1;
                            chip        <= '0;
                            next_b      <= 1'b0;
                            state       <= BLANK;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end

                    BLANK: begin
                        if (bit_val) begin
                            frame_error_q <= 1'b1;
                            busy_q        <= 1'b0;
                            commit_active <= 1'b0;
                            state         <= WAIT_ZERO;
                        end else if (cnt == 7'd15) begin
                            state <= next_b ? HALF_B : HALF_A;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end

                    // The 97th bit decides: 0 is the first blank bit of a normal
                    // gap, 1 means the ones run continues past 96 bits.
                    HALF_A, HALF_B: begin
                        if (cnt != 7'd96) begin
                            shreg <= {shreg[94:0], bit_val};
                            cnt   <= cnt + 7'd1;
                        end else if (!bit_val) begin
                            cbuf          <= shreg;
                            commit_base   <= {8'd0, chip} * 16'd12;
                            commit_half_b <= (state == HALF_B);
                            commit_k      <= '0;
                            commit_active <= 1'b1;
                            state         <= BLANK;
                            cnt           <= 7'd1;
                            next_b        <= ~next_b;
                            if (state == HALF_B && chip != 8'hFF) begin
                                chip <= chip + 8'd1;
                            end
                        end else if (state == HALF_A) begin
                            frame_done_q  <= 1'b1;
                            frame_words_q <= commit_count;
                            busy_q        <= 1'b0;
                            state         <= WAIT_ZERO;
                        end else begin
                            frame_error_q <= 1'b1;
                            busy_q        <= 1'b0;
                            commit_active <= 1'b0;
                            state         <= WAIT_ZERO;
                        end
                    end

                    default: state <= WAIT_ZERO;
                endcase
            end

`ifdef ICND2110_RX_TIMEOUT_EN
            // Idle counter saturates at the limit so it cannot wrap while idle.
            if (bit_evt) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (!bit_evt && busy_q && idle_cnt == IDLE_LIMIT) begin
                frame_error_q <= 1'b1;
                busy_q        <= 1'b0;
                commit_active <= 1'b0;
                state         <= WAIT_ZERO;
            end
`endif
        end
    end

    assign bus.wr_data     = wr_data_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_strobe   = wr_strobe_q;
    assign bus.reg_word    = reg_word_q;
    assign bus.reg_valid   = reg_valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_words = frame_words_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;
endmodule
